regfile_wb: RTL and testbench

REGFILE_WB -- requirements
Module: regfile_wb

---
 rtl/regfile_wb_pkg.sv | 14 +
 rtl/regfile_wb_if.sv | 37 +++
 rtl/regfile_wb_fifo.sv | 55 +++++
 rtl/regfile_wb.sv | 96 +++++++++
 tb/tb_regfile_wb.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_wb_pkg.sv
// Shared constants and the writeback queue entry type for the register-file
// writeback scoreboard.
package regfile_wb_pkg;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;
  localparam int NUM_REGS  = 32;
  localparam int DEPTH_DEF = 4;
  localparam int CNT_W_DEF = 2;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_wb_if.sv
// Issue, writeback, regfile-write and operand-query signals of regfile_wb.
// Handshake rule: a transfer happens on a rising edge where valid and ready are both high.
interface regfile_wb_if;
  import regfile_wb_pkg::*;

  logic              issue_valid;
  logic [REG_W-1:0]  issue_dest;
  logic              issue_ready;
  logic              wb_valid;
  logic [REG_W-1:0]  wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic              wb_ready;
  logic              rf_wr_ready;
  logic              rf_we;
  logic [REG_W-1:0]  rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [REG_W-1:0]  raddr1;
  logic [REG_W-1:0]  raddr2;
  logic              busy1;
  logic              busy2;
  logic              fwd1;
  logic              fwd2;
  logic [DATA_W-1:0] fwd_data1;
  logic [DATA_W-1:0] fwd_data2;

  modport slave (
    input  issue_valid, issue_dest, wb_valid, wb_dest, wb_data, rf_wr_ready, raddr1, raddr2,
    output issue_ready, wb_ready, rf_we, rf_waddr, rf_wdata,
    output busy1, busy2, fwd1, fwd2, fwd_data1, fwd_data2
  );

  modport master (
    output issue_valid, issue_dest, wb_valid, wb_dest, wb_data, rf_wr_ready, raddr1, raddr2,
    input  issue_ready, wb_ready, rf_we, rf_waddr, rf_wdata,
    input  busy1, busy2, fwd1, fwd2, fwd_data1, fwd_data2
  );
endinterface

// File: rtl/regfile_wb_fifo.sv
// In-order writeback queue; every entry is exposed oldest-first with a valid
// bit so the owner can CAM-search it.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  wb_entry_t        push_entry_i,
  input  logic             pop_i,
  output wb_entry_t        head_o,
  output logic             empty_o,
  output logic             full_o,
  output wb_entry_t        entry_o [DEPTH],
  output logic [DEPTH-1:0] entry_vld_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count;
  logic        push_ok, pop_ok;
  wb_entry_t   mem_q [DEPTH];

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
  assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
  assign count    = wr_ptr_q - rd_ptr_q;
  assign head_o   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= push_entry_i;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entry_o[i]     = mem_q[rd_ptr_q[AW-1:0] + AW'(i)];
      entry_vld_o[i] = ((AW+1)'(i) < count);
    end
  end
endmodule

// File: rtl/regfile_wb.sv
// Writeback scoreboard: per-register outstanding-write counters, an in-order
// writeback queue in front of the regfile write port, and operand forwarding.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic         clk,
  input logic         resetn,
  regfile_wb_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] outst_q [NUM_REGS];
  logic [CNT_W-1:0] outst_d [NUM_REGS];
  logic             issue_hs, wb_hs, push, pop, fifo_empty, fifo_full;
  wb_entry_t        head, push_entry;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] entry_vld;
  logic             hit1, hit2;
  logic [DATA_W-1:0] hit_data1, hit_data2;

  assign bus.issue_ready = !((bus.issue_dest != '0) && (outst_q[bus.issue_dest] == CNT_MAX));
  assign bus.wb_ready    = !fifo_full;
  assign issue_hs   = bus.issue_valid && bus.issue_ready;
  assign wb_hs      = bus.wb_valid && bus.wb_ready;
  assign push       = wb_hs && (bus.wb_dest != '0);
  assign pop        = !fifo_empty && bus.rf_wr_ready;
  assign push_entry = '{dest: bus.wb_dest, data: bus.wb_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk          (clk),
    .resetn       (resetn),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .entry_o      (entries),
    .entry_vld_o  (entry_vld)
  );

  assign bus.rf_we    = pop;
  assign bus.rf_waddr = fifo_empty ? '0 : head.dest;
  assign bus.rf_wdata = fifo_empty ? '0 : head.data;

  // Simultaneous issue and writeback to one register cancel; a writeback never drops below zero.
  always_comb begin
    logic inc, dec;
    inc = 1'b0;
    dec = 1'b0;
    outst_d[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      outst_d[r] = outst_q[r];
      inc = issue_hs && (bus.issue_dest == REG_W'(r));
      dec = wb_hs && (bus.wb_dest == REG_W'(r));
      if (inc && !dec) outst_d[r] = outst_q[r] + 1'b1;
      else if (dec && !inc && (outst_q[r] != '0)) outst_d[r] = outst_q[r] - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NUM_REGS; r++) outst_q[r] <= '0;
    end else begin
      outst_q <= outst_d;
    end
  end

  // Entries are ordered oldest-first, so the last hit is the youngest.
  always_comb begin
    hit1      = 1'b0;
    hit2      = 1'b0;
    hit_data1 = '0;
    hit_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_vld[i] && (entries[i].dest == bus.raddr1)) begin
        hit1      = 1'b1;
        hit_data1 = entries[i].data;
      end
      if (entry_vld[i] && (entries[i].dest == bus.raddr2)) begin
        hit2      = 1'b1;
        hit_data2 = entries[i].data;
      end
    end
  end

  assign bus.busy1     = (bus.raddr1 != '0) && (outst_q[bus.raddr1] != '0);
  assign bus.busy2     = (bus.raddr2 != '0) && (outst_q[bus.raddr2] != '0);
  assign bus.fwd1      = (bus.raddr1 != '0) && !bus.busy1 && hit1;
  assign bus.fwd2      = (bus.raddr2 != '0) && !bus.busy2 && hit2;
  assign bus.fwd_data1 = bus.fwd1 ? hit_data1 : '0;
  assign bus.fwd_data2 = bus.fwd2 ? hit_data2 : '0;
endmodule

// File: tb/tb_regfile_wb.sv
// Bench for regfile_wb: directed scenarios then random traffic, every output
// compared each cycle against a queue/array reference model.
module tb_regfile_wb;
  import regfile_wb_pkg::*;

  localparam int DEPTH   = 4;
  localparam int CNT_MAX = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  regfile_wb_if bus();

  regfile_wb #(.DEPTH(DEPTH), .CNT_W(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // reference model: outstanding writes per register and queued {dest,data}
  int         m_outst [32];
  logic [36:0] exp_q [$];

  function automatic void model_reset();
    foreach (m_outst[r]) m_outst[r] = 0;
    exp_q.delete();
  endfunction

  function automatic void model_query(input logic [4:0] ra, output logic busy,
                                      output logic fwd, output logic [31:0] data);
    busy = (ra != 0) && (m_outst[ra] != 0);
    fwd  = 1'b0;
    data = '0;
    if (ra != 0 && !busy)
      foreach (exp_q[k])
        if (exp_q[k][36:32] == ra) begin
          fwd  = 1'b1;
          data = exp_q[k][31:0];
        end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic exp_ir, exp_wr, b, f;
    logic [31:0] d;
    exp_ir = !(bus.issue_dest != 0 && m_outst[bus.issue_dest] == CNT_MAX);
    exp_wr = exp_q.size() < DEPTH;
    check("issue_ready", bus.issue_ready, exp_ir);
    check("wb_ready", bus.wb_ready, exp_wr);
    check("rf_we", bus.rf_we, exp_q.size() > 0 && bus.rf_wr_ready);
    check("rf_waddr", bus.rf_waddr, exp_q.size() > 0 ? 32'(exp_q[0][36:32]) : 32'd0);
    check("rf_wdata", bus.rf_wdata, exp_q.size() > 0 ? exp_q[0][31:0] : 32'd0);
    model_query(bus.raddr1, b, f, d);
    check("busy1", bus.busy1, b);
    check("fwd1", bus.fwd1, f);
    check("fwd_data1", bus.fwd_data1, d);
    model_query(bus.raddr2, b, f, d);
    check("busy2", bus.busy2, b);
    check("fwd2", bus.fwd2, f);
    check("fwd_data2", bus.fwd_data2, d);
  endtask

  function automatic void model_edge();
    logic ir, wr, ihs, whs, pop;
    int id, wd;
    id  = bus.issue_dest;
    wd  = bus.wb_dest;
    ir  = !(id != 0 && m_outst[id] == CNT_MAX);
    wr  = exp_q.size() < DEPTH;
    ihs = bus.issue_valid && ir;
    whs = bus.wb_valid && wr;
    pop = exp_q.size() > 0 && bus.rf_wr_ready;
    if (!(ihs && whs && id == wd)) begin
      if (ihs && id != 0) m_outst[id]++;
      if (whs && wd != 0 && m_outst[wd] > 0) m_outst[wd]--;
    end
    if (pop) void'(exp_q.pop_front());
    if (whs && wd != 0) exp_q.push_back({bus.wb_dest, bus.wb_data});
  endfunction

  // driver tasks
  task automatic drive(input logic iv, input logic [4:0] id, input logic wv,
                       input logic [4:0] wd, input logic [31:0] wdat, input logic rwr);
    bus.issue_valid = iv;
    bus.issue_dest  = id;
    bus.wb_valid    = wv;
    bus.wb_dest     = wd;
    bus.wb_data     = wdat;
    bus.rf_wr_ready = rwr;
  endtask

  task automatic idle(input logic rwr);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 32'd0, rwr);
  endtask

  task automatic cycle();
    #1 compare_all();
    @(posedge clk);
    if (resetn) model_edge();
    @(negedge clk);
  endtask

  initial begin
    idle(1'b0);
    bus.raddr1 = '0;
    bus.raddr2 = '0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    #1 compare_all();
    check("reset_wb_ready", bus.wb_ready, 1'b1);
    resetn = 1'b1;
    @(negedge clk);

    // single result: busy, then forwarded, then written and gone
    bus.raddr1 = 5'd5;
    drive(1'b1, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle();
    drive(1'b0, 5'd0, 1'b1, 5'd5, 32'h1234, 1'b0);
    #1 check("r5_busy_before_wb", bus.busy1, 1'b1);
    cycle();
    idle(1'b0);
    #1 check("r5_busy_after_wb", bus.busy1, 1'b0);
    check("r5_fwd", bus.fwd1, 1'b1);
    check("r5_fwd_data", bus.fwd_data1, 32'h1234);
    cycle();
    idle(1'b1);
    #1 check("r5_rf_we", bus.rf_we, 1'b1);
    check("r5_rf_waddr", bus.rf_waddr, 32'd5);
    cycle();
    idle(1'b1);
    #1 check("r5_fwd_after_write", bus.fwd1, 1'b0);
    cycle();

    // counter saturation on r7 and youngest-entry forwarding
    bus.raddr1 = 5'd7;
    repeat (3) begin
      drive(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0);
      cycle();
    end
    drive(1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0);
    #1 check("r7_issue_stall", bus.issue_ready, 1'b0);
    cycle();
    drive(1'b0, 5'd0, 1'b1, 5'd7, 32'hA, 1'b0);
    cycle();
    drive(1'b0, 5'd0, 1'b1, 5'd7, 32'hB, 1'b0);
    cycle();
    drive(1'b0, 5'd0, 1'b1, 5'd7, 32'hC, 1'b0);
    #1 check("r7_busy_before_last", bus.busy1, 1'b1);
    cycle();
    idle(1'b0);
    #1 check("r7_busy_done", bus.busy1, 1'b0);
    check("r7_fwd_youngest", bus.fwd_data1, 32'hC);
    cycle();
    repeat (3) begin
      idle(1'b1);
      cycle();
    end

    // fill the queue, fifth result refused, drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 5'd0, 1'b1, 5'(i + 1), 32'h100 + i, 1'b0);
      cycle();
    end
    drive(1'b0, 5'd0, 1'b1, 5'd5, 32'h104, 1'b0);
    #1 check("full_wb_ready", bus.wb_ready, 1'b0);
    cycle();
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      #1 check("drain_we", bus.rf_we, 1'b1);
      check("drain_addr", bus.rf_waddr, 32'(i + 1));
      check("drain_data", bus.rf_wdata, 32'h100 + i);
      cycle();
    end

    // simultaneous issue and writeback on r9
    bus.raddr1 = 5'd9;
    drive(1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle();
    drive(1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 1'b0);
    cycle();
    idle(1'b0);
    #1 check("r9_still_busy", bus.busy1, 1'b1);
    cycle();
    drive(1'b0, 5'd0, 1'b1, 5'd9, 32'h9A, 1'b0);
    cycle();
    repeat (2) begin
      idle(1'b1);
      cycle();
    end

    // register zero is ignored
    bus.raddr1 = 5'd0;
    drive(1'b1, 5'd0, 1'b1, 5'd0, 32'hFFFF, 1'b1);
    #1 check("r0_issue_ready", bus.issue_ready, 1'b1);
    cycle();
    idle(1'b1);
    #1 check("r0_no_write", bus.rf_we, 1'b0);
    check("r0_busy", bus.busy1, 1'b0);
    check("r0_fwd", bus.fwd1, 1'b0);
    cycle();

    // random traffic
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
            $urandom(), 1'($urandom_range(0, 2) != 0));
      bus.raddr1 = 5'($urandom_range(0, 7));
      bus.raddr2 = 5'($urandom_range(0, 7));
      cycle();
    end
    repeat (6) begin
      idle(1'b1);
      cycle();
    end

    // asynchronous reset with three queued results
    bus.raddr1 = 5'd2;
    bus.raddr2 = 5'd0;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b0, 5'd0, 1'b1, 5'(i), 32'h300 + i, 1'b0);
      cycle();
    end
    idle(1'b1);
    #1 check("pre_reset_we", bus.rf_we, 1'b1);
    resetn = 1'b0;
    model_reset();
    #1 check("async_rf_we", bus.rf_we, 1'b0);
    check("async_waddr", bus.rf_waddr, 32'd0);
    check("async_wdata", bus.rf_wdata, 32'd0);
    check("async_wb_ready", bus.wb_ready, 1'b1);
    check("async_fwd", bus.fwd1, 1'b0);
    compare_all();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) begin
      idle(1'b1);
      #1 check("post_reset_no_we", bus.rf_we, 1'b0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
